// File: rtl/vga_fill_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fill_sequencer_pkg
//  Description : Shared widths, colour codes and fill-state encoding for the
//                VGA rectangle-fill engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_fill_sequencer_pkg;

    localparam int VGA_COLOR_W = 3;
    localparam int VGA_X_W     = 8;
    localparam int VGA_Y_W     = 8;

    // 3-bit RGB: bit2 = red, bit1 = green, bit0 = blue
    localparam logic [VGA_COLOR_W-1:0] COLOR_BLACK   = 3'd0;
    localparam logic [VGA_COLOR_W-1:0] COLOR_BLUE    = 3'd1;
    localparam logic [VGA_COLOR_W-1:0] COLOR_GREEN   = 3'd2;
    localparam logic [VGA_COLOR_W-1:0] COLOR_CYAN    = 3'd3;
    localparam logic [VGA_COLOR_W-1:0] COLOR_RED     = 3'd4;
    localparam logic [VGA_COLOR_W-1:0] COLOR_MAGENTA = 3'd5;
    localparam logic [VGA_COLOR_W-1:0] COLOR_YELLOW  = 3'd6;
    localparam logic [VGA_COLOR_W-1:0] COLOR_WHITE   = 3'd7;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    function automatic logic checker_odd(input logic x_lsb, input logic y_lsb);
        return x_lsb ^ y_lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_xy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_xy_counter
//  Description : Two-level raster counter (X inner, Y outer) with equality
//                terminals. Outputs the pixel addressed this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_xy_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           iLoad,
    input  logic           iStep,
    input  logic [X_W-1:0] iX0,
    input  logic [X_W-1:0] iX1,
    input  logic [Y_W-1:0] iY0,
    input  logic [Y_W-1:0] iY1,
    output logic [X_W-1:0] oCurX,
    output logic [Y_W-1:0] oCurY,
    output logic           oLast
);
    logic [X_W-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0] y_q, y_d, y1_q, y1_d;

    // A load presents the first pixel in the same cycle so it can be written
    // and stepped past immediately.
    always_comb begin
        x0_d  = iLoad ? iX0 : x0_q;
        x1_d  = iLoad ? iX1 : x1_q;
        y1_d  = iLoad ? iY1 : y1_q;
        oCurX = iLoad ? iX0 : x_q;
        oCurY = iLoad ? iY0 : y_q;
        oLast = (oCurX == x1_d) && (oCurY == y1_d);
        x_d   = oCurX;
        y_d   = oCurY;
        if (iStep) begin
            if (oCurX == x1_d) begin
                x_d = x0_d;
                y_d = oCurY + 1'b1;
            end else begin
                x_d = oCurX + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            x0_q <= x0_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fill_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fill_sequencer
//  Description : Rectangle-fill engine sharing the video-RAM write port with
//                CPU writes (CPU wins). Optional: VGA_FILL_CHECKER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fill_sequencer
    import vga_fill_sequencer_pkg::*;
#(
    parameter int COLOR_W = VGA_COLOR_W,
    parameter int X_W     = VGA_X_W,
    parameter int Y_W     = VGA_Y_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [X_W-1:0]     iX0,
    input  logic [X_W-1:0]     iX1,
    input  logic [Y_W-1:0]     iY0,
    input  logic [Y_W-1:0]     iY1,
    input  logic [COLOR_W-1:0] iColor,
    input  logic [COLOR_W-1:0] iColorAlt,
    input  logic               iCpuWe,
    input  logic [X_W-1:0]     iCpuX,
    input  logic [Y_W-1:0]     iCpuY,
    input  logic [COLOR_W-1:0] iCpuColor,
    output logic               oWe,
    output logic [X_W-1:0]     oX,
    output logic [Y_W-1:0]     oY,
    output logic [COLOR_W-1:0] oColor,
    output logic               oBusy,
    output logic               oDone
);
    fill_state_t        state_q, state_d;
    logic               we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d, fill_color_q, fill_color_d;
    logic [COLOR_W-1:0] pix_color;
    logic               start_ok, bounds_ok, cnt_load, fill_slot;
    logic [X_W-1:0]     cur_x;
    logic [Y_W-1:0]     cur_y;
    logic               cur_last;
`ifdef VGA_FILL_CHECKER_EN
    logic [COLOR_W-1:0] alt_color_q, alt_color_d;
`else
    logic               unused_color_alt;
    assign unused_color_alt = ^iColorAlt;
`endif

    vga_xy_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_counter (
        .Clock (Clock),
        .Reset (Reset),
        .iLoad (cnt_load),
        .iStep (fill_slot),
        .iX0   (iX0),
        .iX1   (iX1),
        .iY0   (iY0),
        .iY1   (iY1),
        .oCurX (cur_x),
        .oCurY (cur_y),
        .oLast (cur_last)
    );

    always_comb begin
        start_ok     = (state_q == FILL_IDLE) && iStart && !iAbort;
        bounds_ok    = (iX0 <= iX1) && (iY0 <= iY1);
        cnt_load     = start_ok && bounds_ok;
        // A fill pixel goes out only in a slot the CPU leaves free.
        fill_slot    = (cnt_load || ((state_q == FILL_RUN) && !iAbort)) && !iCpuWe;
        fill_color_d = start_ok ? iColor : fill_color_q;
`ifdef VGA_FILL_CHECKER_EN
        alt_color_d  = start_ok ? iColorAlt : alt_color_q;
        pix_color    = checker_odd(cur_x[0], cur_y[0]) ? alt_color_d : fill_color_d;
`else
        pix_color    = fill_color_d;
`endif

        state_d = state_q;
        case (state_q)
            FILL_IDLE: begin
                if (start_ok) begin
                    if (!bounds_ok)
                        state_d = FILL_DONE;
                    else if (fill_slot && cur_last)
                        state_d = FILL_DONE;
                    else
                        state_d = FILL_RUN;
                end
            end
            FILL_RUN: begin
                if (iAbort)
                    state_d = FILL_IDLE;
                else if (fill_slot && cur_last)
                    state_d = FILL_DONE;
            end
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase

        we_d    = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        if (iCpuWe) begin
            we_d    = 1'b1;
            x_d     = iCpuX;
            y_d     = iCpuY;
            color_d = iCpuColor;
        end else if (fill_slot) begin
            we_d    = 1'b1;
            x_d     = cur_x;
            y_d     = cur_y;
            color_d = pix_color;
        end
        busy_d = (state_d == FILL_RUN) || fill_slot;
        done_d = (state_q == FILL_DONE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= FILL_IDLE;
            we_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fill_color_q <= '0;
`ifdef VGA_FILL_CHECKER_EN
            alt_color_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fill_color_q <= fill_color_d;
`ifdef VGA_FILL_CHECKER_EN
            alt_color_q  <= alt_color_d;
`endif
        end
    end

    assign oWe    = we_q;
    assign oX     = x_q;
    assign oY     = y_q;
    assign oColor = color_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fill_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_fill_sequencer
//  Description : Table-driven and randomized bench for vga_fill_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fill_sequencer;
    import vga_fill_sequencer_pkg::*;

    localparam int MAXE = 600;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iStart, iAbort, iCpuWe;
    logic [7:0] iX0, iX1, iY0, iY1, iCpuX, iCpuY;
    logic [2:0] iColor, iColorAlt, iCpuColor;
    logic       oWe, oBusy, oDone;
    logic [7:0] oX, oY;
    logic [2:0] oColor;

    int n_vec = 0;
    int n_bad = 0;

    // last values driven onto the write port, as the model sees them
    logic [7:0] m_x, m_y;
    logic [2:0] m_c;

    always #5 Clock = ~Clock;

    vga_fill_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iStart    (iStart),
        .iAbort    (iAbort),
        .iX0       (iX0),
        .iX1       (iX1),
        .iY0       (iY0),
        .iY1       (iY1),
        .iColor    (iColor),
        .iColorAlt (iColorAlt),
        .iCpuWe    (iCpuWe),
        .iCpuX     (iCpuX),
        .iCpuY     (iCpuY),
        .iCpuColor (iCpuColor),
        .oWe       (oWe),
        .oX        (oX),
        .oY        (oY),
        .oColor    (oColor),
        .oBusy     (oBusy),
        .oDone     (oDone)
    );

    typedef struct {
        logic [7:0] x0, x1, y0, y1;
        logic [2:0] col, alt;
        int         cpu_e, abort_e, restart_e;
        int         exp_writes, exp_done_e;
    } vec_t;

    vec_t tbl [9];

    task automatic check_out(input string tag, input int idx, input logic we,
                             input logic [7:0] x, input logic [7:0] y,
                             input logic [2:0] c, input logic busy, input logic done);
        n_vec++;
        if ({oWe, oX, oY, oColor, oBusy, oDone} !== {we, x, y, c, busy, done}) begin
            n_bad++;
            $display("FAIL %s[%0d]: got we=%b x=%0d y=%0d c=%0d busy=%b done=%b, want we=%b x=%0d y=%0d c=%0d busy=%b done=%b",
                     tag, idx, oWe, oX, oY, oColor, oBusy, oDone, we, x, y, c, busy, done);
        end
    endtask

    task automatic check_int(input string tag, input int idx, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d, want %0d", tag, idx, got, want);
        end
    endtask

    // Reference: build the raster pixel list, then per edge the CPU takes the
    // port if it asks, otherwise the next pending pixel goes out.
    task automatic run_case(input string tag, input logic [7:0] x0, input logic [7:0] x1,
                            input logic [7:0] y0, input logic [7:0] y1,
                            input logic [2:0] col, input logic [2:0] alt,
                            input int cpu_e, input int cpu_rate, input int abort_e,
                            input int restart_e, output int writes, output int done_e);
        logic [7:0] px[$];
        logic [7:0] py[$];
        int         idx, phase, fin_cnt, e;
        bit         valid, cpu;
        logic [7:0] cx, cy;
        logic [2:0] cc;
        logic       ew, eb, ed;
        for (int yy = int'(y0); yy <= int'(y1); yy++)
            for (int xx = int'(x0); xx <= int'(x1); xx++) begin
                px.push_back(8'(xx));
                py.push_back(8'(yy));
            end
        valid   = (x0 <= x1) && (y0 <= y1);
        writes  = 0;
        done_e  = -1;
        idx     = 0;
        fin_cnt = 0;
        phase   = (abort_e == 0) ? 2 : 0;
        for (e = 0; e < MAXE && fin_cnt < 3; e++) begin
            cpu = (e == cpu_e) || (cpu_rate > 0 && phase != 2 && $urandom_range(99) < cpu_rate);
            if (e == cpu_e) begin
                cx = 8'd10; cy = 8'd20; cc = COLOR_RED;
            end else begin
                cx = 8'($urandom); cy = 8'($urandom); cc = 3'($urandom);
            end
            iStart = (e == 0) || (e == restart_e);
            if (e == 0) begin
                iX0 = x0; iX1 = x1; iY0 = y0; iY1 = y1; iColor = col; iColorAlt = alt;
            end else begin
                iX0 = 8'd0; iX1 = 8'd0; iY0 = 8'd0; iY1 = 8'd0;
                iColor = COLOR_WHITE; iColorAlt = COLOR_WHITE;
            end
            iAbort = (e == abort_e); iCpuWe = cpu; iCpuX = cx; iCpuY = cy; iCpuColor = cc;
            @(posedge Clock); #1;
            ew = 1'b0; eb = 1'b0; ed = 1'b0;
            if (cpu) begin
                ew = 1'b1; m_x = cx; m_y = cy; m_c = cc;
            end
            case (phase)
                0: begin
                    if (!valid) phase = 1;
                    else if (abort_e > 0 && e >= abort_e) phase = 2;
                    else begin
                        eb = 1'b1;
                        if (!cpu) begin
                            ew = 1'b1; m_x = px[idx]; m_y = py[idx];
`ifdef VGA_FILL_CHECKER_EN
                            m_c = (px[idx][0] ^ py[idx][0]) ? alt : col;
`else
                            m_c = col;
`endif
                            idx++;
                            if (idx == px.size()) phase = 1;
                        end
                    end
                end
                1: begin
                    ed = 1'b1; phase = 2;
                end
                default: fin_cnt++;
            endcase
            check_out(tag, e, ew, m_x, m_y, m_c, eb, ed);
            if (oWe) writes++;
            if (oDone && done_e < 0) done_e = e;
        end
        if (fin_cnt < 3) begin
            n_vec++; n_bad++;
            $display("FAIL %s timeout: got %0d edges, want fill to finish", tag, e);
        end
        iStart = 1'b0; iAbort = 1'b0; iCpuWe = 1'b0;
    endtask

    initial begin
        int w, de, a, b, c, d, sx, sy, ab, tmp;
        tbl[0] = '{8'd0,   8'd3,   8'd0,   8'd1,   COLOR_GREEN,   COLOR_BLACK,  -1, -1, -1, 8, 8};
        tbl[1] = '{8'd0,   8'd3,   8'd0,   8'd1,   COLOR_GREEN,   COLOR_BLACK,   2, -1, -1, 9, 9};
        tbl[2] = '{8'd5,   8'd4,   8'd0,   8'd0,   COLOR_GREEN,   COLOR_BLACK,  -1, -1, -1, 0, 1};
        tbl[3] = '{8'd254, 8'd255, 8'd255, 8'd255, COLOR_CYAN,    COLOR_BLACK,  -1, -1,  1, 2, 2};
        tbl[4] = '{8'd0,   8'd3,   8'd0,   8'd1,   COLOR_GREEN,   COLOR_BLACK,  -1,  4, -1, 4, -1};
        tbl[5] = '{8'd0,   8'd1,   8'd0,   8'd1,   COLOR_BLUE,    COLOR_YELLOW, -1, -1, -1, 4, 4};
        tbl[6] = '{8'd7,   8'd7,   8'd3,   8'd3,   COLOR_MAGENTA, COLOR_BLACK,  -1, -1, -1, 1, 1};
        tbl[7] = '{8'd0,   8'd3,   8'd0,   8'd1,   COLOR_GREEN,   COLOR_BLACK,  -1,  0, -1, 0, -1};
        tbl[8] = '{8'd0,   8'd1,   8'd0,   8'd0,   COLOR_WHITE,   COLOR_BLACK,   0, -1, -1, 3, 3};

        Reset = 1'b0; iStart = 1'b0; iAbort = 1'b0; iCpuWe = 1'b0;
        iX0 = '0; iX1 = '0; iY0 = '0; iY1 = '0; iColor = '0; iColorAlt = '0;
        iCpuX = '0; iCpuY = '0; iCpuColor = '0;
        m_x = '0; m_y = '0; m_c = '0;
        repeat (3) @(posedge Clock);
        #1;
        check_out("reset_state", 0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

        // reset in the middle of a large fill abandons it
        Reset = 1'b1;
        iStart = 1'b1; iX0 = 8'd0; iX1 = 8'd255; iY0 = 8'd0; iY1 = 8'd63; iColor = COLOR_GREEN;
        @(posedge Clock); #1;
        iStart = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            check_out("mid_reset", i, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        end
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock); #1;
            check_out("after_reset", i, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 9; i++) begin
            run_case("tbl", tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].col, tbl[i].alt,
                     tbl[i].cpu_e, 0, tbl[i].abort_e, tbl[i].restart_e, w, de);
            check_int("tbl_writes", i, w, tbl[i].exp_writes);
            check_int("tbl_done_edge", i, de, tbl[i].exp_done_e);
        end

        for (int r = 0; r < 40; r++) begin
            sx = $urandom_range(7);
            sy = $urandom_range(7);
            a  = $urandom_range(255);
            c  = $urandom_range(255);
            if ($urandom_range(3) == 0) a = 255 - sx;
            if ($urandom_range(3) == 0) c = 255 - sy;
            b = (a + sx > 255) ? 255 : a + sx;
            d = (c + sy > 255) ? 255 : c + sy;
            if ($urandom_range(7) == 0 && a != b) begin
                tmp = a; a = b; b = tmp;
            end
            ab = -1;
            if (a <= b && $urandom_range(5) == 0)
                ab = $urandom_range(1, (b - a + 1) * (d - c + 1));
            run_case("rand", 8'(a), 8'(b), 8'(c), 8'(d), 3'($urandom), 3'($urandom),
                     -1, 20, ab, -1, w, de);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fill_sequencer.md
Name: vga_fill_sequencer

Overview:
- Hardware rectangle-fill engine for the VGA video RAM write port. It replaces the nested INC/BLE software loops the CPU otherwise runs per colour band.
- The CPU loads bounds and a colour, then pulses start. The block walks every pixel in the rectangle and issues one RAM write per cycle.
- It arbitrates the single video-RAM write port between its own fill writes and direct CPU VGA-instruction writes. CPU writes have priority.

Parameters:
- COLOR_W, 3: colour width, matching the COLOR_* encodings.
- X_W, 8: row-address (X, inner loop) width.
- Y_W, 8: column-address (Y, outer loop) width.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- iStart  in  1  one-cycle fill request.
- iAbort  in  1  cancel the fill in progress.
- iX0  in  X_W  first row.
- iX1  in  X_W  last row, inclusive.
- iY0  in  Y_W  first column.
- iY1  in  Y_W  last column, inclusive.
- iColor  in  COLOR_W  fill colour.
- iColorAlt  in  COLOR_W  second colour; used only with FILL_CHECKER_EN.
- iCpuWe  in  1  CPU VGA-instruction write strobe.
- iCpuX  in  X_W  CPU write row.
- iCpuY  in  Y_W  CPU write column.
- iCpuColor  in  COLOR_W  CPU write colour.
- oWe  out  1  video-RAM write enable.
- oX  out  X_W  video-RAM row address.
- oY  out  Y_W  video-RAM column address.
- oColor  out  COLOR_W  video-RAM write data.
- oBusy  out  1  high while a fill is active.
- oDone  out  1  one-cycle pulse when a fill completes normally.

Behaviour:
- All outputs are registered. Reset (Reset==0 at a rising edge) forces:
  - state IDLE;
  - oWe, oBusy and oDone to 0;
  - oX, oY and oColor to 0;
  - internal counters to 0.
- Reset asserted mid-fill abandons the fill immediately. No oDone is produced.
- States:
  - IDLE:
    - iStart=1 latches iX0, iX1, iY0, iY1, iColor and iColorAlt.
    - If iX0>iX1 or iY0>iY1: go to DONE. No writes are issued.
    - Otherwise load x=iX0, y=iY0 and go to FILL. oBusy=1 from the next cycle.
  - FILL:
    - Each cycle without a CPU write, the next cycle has oWe=1, oX=x, oY=y, oColor=colour.
    - The counter then advances. If x==X1: x=X0 and y=y+1. Otherwise x=x+1.
    - After the write at (X1,Y1), go to DONE.
    - Comparisons are equality against the latched bounds, so X1=255 and Y1=255 never wrap past their maximum.
  - DONE: oDone=1 and oBusy=0 for one cycle, then IDLE.
- Timing and throughput:
  - iStart sampled at edge N gives the first fill write on the port during cycle N+1.
  - With no CPU traffic, the fill takes (X1-X0+1)*(Y1-Y0+1) consecutive write cycles. oDone follows the cycle after the last write.
  - Maximum fill is 65536 writes.
- Arbitration:
  - iCpuWe=1 at edge N gives oWe=1 during cycle N+1 with the CPU address and colour. This holds in every state.
  - If this happens in FILL, the fill counter holds that cycle. No pixel is skipped or duplicated.
- Ignored or cancelled requests:
  - iStart while in FILL or DONE is ignored. The latched bounds do not change.
  - iAbort in FILL: go to IDLE next cycle. oBusy=0, no oDone. Writes already issued remain.
  - iAbort in IDLE or DONE has no effect.
  - iAbort together with iStart in IDLE: abort wins and the start is dropped.
- oWe=0 in any cycle with neither a fill write nor a CPU write. oX, oY and oColor hold their last values.

Optional Feature:
- VGA_FILL_CHECKER_EN
  - Defined: fill colour is iColor when (x^y)[0]==0 and iColorAlt otherwise, computed from the counter values of the pixel being written.
  - Undefined: iColorAlt is unused, and every fill pixel is iColor.
- CPU passthrough writes are unaffected in both cases.

Decomposition:
- Shared package/include, alongside the existing definitions header:
  - state encoding constants FILL_IDLE=2'd0, FILL_RUN=2'd1, FILL_DONE=2'd2;
  - COLOR_W, X_W and Y_W defaults;
  - the existing COLOR_* values.
- One natural sub-module: vga_xy_counter, the two-level X/Y raster counter with load, enable, equality-terminal and last-pixel flag.
- The arbiter mux and FSM stay in the top module.

Test Plan:
- Reset held low 3 cycles during a fill of (0..255,0..63) -> oWe=0, oBusy=0, oDone=0. No further writes after release.
- Start with X0=0, X1=3, Y0=0, Y1=1, iColor=GREEN, no CPU traffic:
  - exactly 8 writes in order (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1), all GREEN;
  - first write the cycle after start, oDone one cycle after the last write.
- Same fill with iCpuWe=1 (X=10, Y=20, RED) on the third fill cycle:
  - one RED write to (10,20) is inserted;
  - fill resumes at (2,0); 9 writes total; oDone delayed one cycle.
- Start with X0=5, X1=4 -> zero writes; oDone one cycle after start; oBusy never high.
- Fill X0=254, X1=255, Y0=255, Y1=255:
  - writes (254,255),(255,255) then DONE, with no wrap to 0;
  - a second iStart during the fill is ignored.
- iAbort on the 4th write of the 8-pixel fill -> exactly 4 writes, oBusy low next cycle, no oDone.
- With VGA_FILL_CHECKER_EN, iColor=BLUE, iColorAlt=YELLOW, 2x2 fill -> (0,0)=BLUE, (1,0)=YELLOW, (0,1)=YELLOW, (1,1)=BLUE.
